// File: rtl/dtc_vote_accum_if.sv
// Handshake bundle for the vote accumulator: prediction input stream,
// flush strobe and the majority-vote result stream.
interface dtc_vote_accum_if #(
  parameter int CLASS_W   = 3,
  parameter int FRAME_LEN = 16
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic               in_valid;
  logic               in_ready;
  logic [CLASS_W-1:0] in_class;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic [CNT_W-1:0]   out_count;
  logic               out_tie;

  modport master (
    output in_valid, in_class, flush, out_ready,
    input  in_ready, out_valid, out_class, out_count, out_tie
  );

  modport slave (
    input  in_valid, in_class, flush, out_ready,
    output in_ready, out_valid, out_class, out_count, out_tie
  );
endinterface

// File: rtl/dtc_vote_accum.sv
// Majority-vote accumulator: histograms a frame of class predictions,
// scans it one class per cycle, then holds majority/count/tie on the bus.
module dtc_vote_accum #(
  parameter int CLASS_W   = 3,
  parameter int FRAME_LEN = 16
) (
  input logic           clk,
  input logic           rst,
  dtc_vote_accum_if.slave bus
);
  localparam int NUM_CLASSES = 2 ** CLASS_W;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt [NUM_CLASSES];
  logic [CNT_W-1:0]   samples;
  logic [CLASS_W-1:0] idx;
  logic [CLASS_W-1:0] best, best_nx;
  logic [CNT_W-1:0]   best_cnt, best_cnt_nx;
  logic               tie, tie_nx;
  logic [CLASS_W-1:0] res_class;
  logic [CNT_W-1:0]   res_count;
  logic               res_tie;
  logic               accept, take, in_rdy, out_vld;
  logic [CNT_W-1:0]   cur;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    accept   = 1'b0;
    take     = 1'b0;
    unique case (state)
      ACCUM: begin
        in_rdy = 1'b1;
        accept = bus.in_valid;
        // a flush on an empty frame has nothing to report
        if ((accept && samples == LAST_BEAT) ||
            (bus.flush && (accept || samples != '0)))
          state_nx = SCAN;
      end
      SCAN: begin
        if (idx == LAST_IDX) state_nx = HOLD;
      end
      HOLD: begin
        out_vld = 1'b1;
        take    = bus.out_ready;
        if (take) state_nx = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  // strict greater-than keeps the lowest index on equal counts
  always_comb begin
    cur         = cnt[idx];
    best_nx     = best;
    best_cnt_nx = best_cnt;
    tie_nx      = tie;
    if (cur > best_cnt) begin
      best_nx     = idx;
      best_cnt_nx = cur;
      tie_nx      = 1'b0;
    end else if (cur == best_cnt && cur != '0) begin
      tie_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      samples   <= '0;
      idx       <= '0;
      best      <= '0;
      best_cnt  <= '0;
      tie       <= 1'b0;
      res_class <= '0;
      res_count <= '0;
      res_tie   <= 1'b0;
    end else begin
      if (accept) begin
        cnt[bus.in_class] <= cnt[bus.in_class] + 1'b1;
        samples <= samples + 1'b1;
      end
      if (state == ACCUM) begin
        idx      <= '0;
        best     <= '0;
        best_cnt <= '0;
        tie      <= 1'b0;
      end
      if (state == SCAN) begin
        idx      <= idx + 1'b1;
        best     <= best_nx;
        best_cnt <= best_cnt_nx;
        tie      <= tie_nx;
        if (idx == LAST_IDX) begin
          res_class <= best_nx;
          res_count <= best_cnt_nx;
          res_tie   <= tie_nx;
        end
      end
      if (take) begin
        for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
        samples <= '0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_class = res_class;
  assign bus.out_count = res_count;
  assign bus.out_tie   = res_tie;
endmodule
